// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter: runtime step, wrap or saturate at [MIN_VAL, MAX_VAL], clamped load, tc pulse.
// Optional sticky terminal-count flag (ovf/ovf_clr) when UDC_OVF_STICKY_EN is defined.
module bounded_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 255,
    parameter int WRAP    = 1,
    parameter int STEP_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  out,
    output logic              at_min,
    output logic              at_max,
    output logic              tc
`ifdef UDC_OVF_STICKY_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf
`endif
);
    // There is no handshake: every edge with enable=1 and up^down=1 is a
    // consumed count; load and reset take precedence over counting.

    localparam int XW = WIDTH + 1;
    localparam logic [WIDTH:0]   L_MIN   = XW'(MIN_VAL);
    localparam logic [WIDTH:0]   L_MAX   = XW'(MAX_VAL);
    localparam logic [WIDTH-1:0] L_MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_min_plus_step;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_load_clamped;
    logic [WIDTH:0]   w_count_val;
    logic             w_count_en;
    logic             w_up_cross;
    logic             w_dn_cross;
    logic             w_tc_next;

    // Arithmetic is one bit wider than the counter so MAX_VAL = 2^WIDTH-1 cannot overflow.
    always_comb begin
        w_cur           = {1'b0, r_out};
        w_step          = (step == '0) ? XW'(1) : XW'(step);
        w_up_sum        = w_cur + w_step;
        w_min_plus_step = L_MIN + w_step;
        w_count_en      = enable & (up ^ down);
        w_up_cross      = (w_up_sum > L_MAX);
        w_dn_cross      = (w_cur < w_min_plus_step);
        w_count_val     = w_cur;
        if (up) begin
            if (!w_up_cross) begin
                w_count_val = w_up_sum;
            end else if (WRAP != 0) begin
                w_count_val = L_MIN + (w_up_sum - L_MAX - XW'(1));
            end else begin
                w_count_val = L_MAX;
            end
        end else begin
            if (!w_dn_cross) begin
                w_count_val = w_cur - w_step;
            end else if (WRAP != 0) begin
                w_count_val = L_MAX - (w_min_plus_step - w_cur - XW'(1));
            end else begin
                w_count_val = L_MIN;
            end
        end
        w_tc_next = ~load & w_count_en & (up ? w_up_cross : w_dn_cross);

        w_load_ext     = {1'b0, load_val};
        w_load_clamped = w_load_ext;
        if (w_load_ext < L_MIN) begin
            w_load_clamped = L_MIN;
        end else if (w_load_ext > L_MAX) begin
            w_load_clamped = L_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= L_MIN_W;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= WIDTH'(w_load_clamped);
            r_tc  <= 1'b0;
        end else if (w_count_en) begin
            r_out <= WIDTH'(w_count_val);
            r_tc  <= w_tc_next;
        end else begin
            r_tc  <= 1'b0;
        end
    end

`ifdef UDC_OVF_STICKY_EN
    logic r_ovf;

    // A terminal count on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_tc_next) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign out    = r_out;
    assign tc     = r_tc;
    assign at_min = (r_out == L_MIN_W);
    assign at_max = (r_out == L_MAX_W);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Bench for bounded_updown_counter: a wrapping and a saturating instance share stimulus;
// expected outputs come from an integer range model and are checked through a queue.
module tb_bounded_updown_counter;
  localparam int W     = 4;
  localparam int MIN_V = 2;
  localparam int MAX_V = 12;
  localparam int SW    = 2;
  localparam int EW    = 16;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          up;
  logic          down;
  logic [SW-1:0] step;
  logic          load;
  logic [W-1:0]  load_val;
  logic          ovf_clr;

  logic [W-1:0]  out_w, out_s;
  logic          at_min_w, at_max_w, tc_w, ovf_w;
  logic          at_min_s, at_max_s, tc_s, ovf_s;

  logic [EW-1:0] exp_q[$];
  int            n_tests;
  int            n_fail;

  int            m_out_w, m_out_s;
  bit            m_ovf_w, m_ovf_s;

  bounded_updown_counter #(
    .WIDTH(W), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .WRAP(1), .STEP_W(SW)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .down(down),
    .step(step), .load(load), .load_val(load_val),
    .out(out_w), .at_min(at_min_w), .at_max(at_max_w), .tc(tc_w)
`ifdef UDC_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(ovf_w)
`endif
  );

  bounded_updown_counter #(
    .WIDTH(W), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .WRAP(0), .STEP_W(SW)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .down(down),
    .step(step), .load(load), .load_val(load_val),
    .out(out_s), .at_min(at_min_s), .at_max(at_max_s), .tc(tc_s)
`ifdef UDC_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(ovf_s)
`endif
  );

`ifndef UDC_OVF_STICKY_EN
  assign ovf_w = 1'b0;
  assign ovf_s = 1'b0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the legal range is a ring of R values when wrapping.
  task automatic model_next(input bit wrap, input int cur, input bit en, input bit u,
                            input bit d, input int st, input bit ld, input int lv,
                            output int nxt, output bit t);
    int r;
    int s;
    int raw;
    r = MAX_V - MIN_V + 1;
    s = (st == 0) ? 1 : st;
    nxt = cur;
    t = 1'b0;
    if (ld) begin
      nxt = (lv < MIN_V) ? MIN_V : ((lv > MAX_V) ? MAX_V : lv);
    end else if (en && (u != d)) begin
      raw = u ? cur + s : cur - s;
      if (raw > MAX_V || raw < MIN_V) begin
        t = 1'b1;
        if (wrap) nxt = MIN_V + ((((raw - MIN_V) % r) + r) % r);
        else      nxt = u ? MAX_V : MIN_V;
      end else begin
        nxt = raw;
      end
    end
  endtask

  // driver
  task automatic drive(input bit rst, input bit en, input bit u, input bit d,
                       input int st, input bit ld, input int lv, input bit clr);
    int  nw, ns;
    bit  tw, ts;
    logic [EW-1:0] e;
    @(negedge clk);
    reset    = rst;
    enable   = en;
    up       = u;
    down     = d;
    step     = SW'(st);
    load     = ld;
    load_val = W'(lv);
    ovf_clr  = clr;
    if (rst) begin
      nw = MIN_V; ns = MIN_V; tw = 1'b0; ts = 1'b0;
      m_ovf_w = 1'b0; m_ovf_s = 1'b0;
    end else begin
      model_next(1'b1, m_out_w, en, u, d, st, ld, lv, nw, tw);
      model_next(1'b0, m_out_s, en, u, d, st, ld, lv, ns, ts);
      if (tw) m_ovf_w = 1'b1; else if (clr) m_ovf_w = 1'b0;
      if (ts) m_ovf_s = 1'b1; else if (clr) m_ovf_s = 1'b0;
    end
    m_out_w = nw;
    m_out_s = ns;
    e = {W'(nw), nw == MIN_V, nw == MAX_V, tw, m_ovf_w,
         W'(ns), ns == MIN_V, ns == MAX_V, ts, m_ovf_s};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every edge that followed a driven cycle presents a result
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wrap_out",    int'(out_w),    int'(e[15:12]));
      check("wrap_at_min", int'(at_min_w), int'(e[11]));
      check("wrap_at_max", int'(at_max_w), int'(e[10]));
      check("wrap_tc",     int'(tc_w),     int'(e[9]));
      check("sat_out",     int'(out_s),    int'(e[7:4]));
      check("sat_at_min",  int'(at_min_s), int'(e[3]));
      check("sat_at_max",  int'(at_max_s), int'(e[2]));
      check("sat_tc",      int'(tc_s),     int'(e[1]));
`ifdef UDC_OVF_STICKY_EN
      check("wrap_ovf",    int'(ovf_w),    int'(e[8]));
      check("sat_ovf",     int'(ovf_s),    int'(e[0]));
`endif
    end
  end

  initial begin
    n_tests = 0; n_fail = 0;
    m_out_w = MIN_V; m_out_s = MIN_V; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
    reset = 1'b1; enable = 1'b0; up = 1'b0; down = 1'b0; step = '0;
    load = 1'b0; load_val = '0; ovf_clr = 1'b0;

    // reset, then disabled counting holds at MIN
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 1, 0, 0, 0);
    // step=1 up through the whole range and one past MAX
    for (int i = 0; i < 11; i++) drive(0, 1, 1, 0, 1, 0, 0, 0);
    // multi-step crossings up and down, then step 0 treated as 1
    drive(0, 0, 0, 0, 0, 1, 11, 0);
    drive(0, 1, 1, 0, 3, 0, 0, 0);
    drive(0, 1, 0, 1, 3, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    // saturation repeats tc while pushing past MAX
    drive(0, 0, 0, 0, 0, 1, 11, 0);
    drive(0, 1, 1, 0, 3, 0, 0, 0);
    drive(0, 1, 1, 0, 3, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 0, 0, 0);
    // priority and load clamping
    drive(0, 1, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 1, 15, 0);
    drive(0, 1, 0, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 7, 0);
    // sticky flag: set beats clear, clear alone, reset mid-count
    drive(0, 0, 0, 0, 0, 1, 12, 0);
    drive(0, 1, 1, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 2, 0, 0, 0);
    drive(0, 1, 1, 0, 3, 0, 0, 0);
    drive(1, 1, 1, 0, 3, 0, 0, 0);
    drive(0, 1, 0, 1, 3, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bounded_updown_counter.md
# bounded_updown_counter

Parametrised up/down counter with runtime step size and programmable bounds. It counts between MIN_VAL and MAX_VAL and either wraps or saturates at those bounds. It also provides a synchronous parallel load and a terminal-count pulse. It replaces the fixed 4-bit up/down counter wherever a wider range, a non-unit step or boundary reporting is needed.

## Interface
Parameters:
- WIDTH, 8, counter width in bits.
- MIN_VAL, 0, lower bound (inclusive). Must satisfy MIN_VAL < MAX_VAL.
- MAX_VAL, 255, upper bound (inclusive). Must be ≤ 2^WIDTH−1.
- WRAP, 1, boundary mode: 1 = modulo wrap, 0 = saturate.
- STEP_W, 2, width of the step input. Must satisfy 2^STEP_W−1 ≤ MAX_VAL−MIN_VAL.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable; does not gate load.
- up  in  1  count-up request.
- down  in  1  count-down request.
- step  in  STEP_W  increment/decrement magnitude; 0 is treated as 1.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  load value.
- out  out  WIDTH  registered count.
- at_min  out  1  combinational, out == MIN_VAL.
- at_max  out  1  combinational, out == MAX_VAL.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf_clr  in  1  clears the sticky flag; present only with UDC_OVF_STICKY_EN.
- ovf  out  1  sticky terminal-count flag; present only with UDC_OVF_STICKY_EN.

## Operation
- Priority per edge: reset > load > count > hold.
- Reset: out=MIN_VAL, tc=0, ovf=0. After reset at_min=1 and at_max=0.
- Load: out = load_val clamped into [MIN_VAL, MAX_VAL]. tc=0. Load applies regardless of enable, up and down.
- Count occurs only when enable=1 and up XOR down is 1. up=down=1 or up=down=0 holds the value with tc=0.
- Let s = max(step, 1). All arithmetic uses WIDTH+1 bits, so MAX_VAL = 2^WIDTH−1 never overflows internally.
- Up, no crossing (out+s ≤ MAX_VAL): out += s, tc=0.
- Up, crossing, WRAP=1: out = MIN_VAL + (out+s−MAX_VAL−1), tc=1.
- Up, crossing, WRAP=0: out = MAX_VAL, tc=1. Counting up while already at MAX_VAL gives tc=1 every counting cycle.
- Down is symmetric.
  - No crossing: out −= s.
  - WRAP=1 crossing: out = MAX_VAL − (MIN_VAL−(out−s)−1), tc=1.
  - WRAP=0 crossing: out = MIN_VAL, tc=1.
- Holding, loading or disabled cycles drive tc=0.
- Reset asserted mid-count overrides everything on that edge.

## Timing
- Controls are sampled at a rising edge. The new out and its tc are visible after that same edge (1-cycle latency).
- at_min and at_max follow out combinationally, with no extra latency.
- tc is high for exactly the cycle following a boundary-crossing count edge. Consecutive crossing counts keep it high.
- No handshake. Every enabled count edge is consumed.

## Configuration
- UDC_OVF_STICKY_EN defined: the ovf_clr and ovf ports exist.
  - ovf sets on any edge that produces tc=1.
  - ovf clears on an ovf_clr edge.
  - If set and clear occur on the same edge, set wins.
  - reset clears ovf.
- UDC_OVF_STICKY_EN undefined: ovf_clr and ovf are absent. No sticky state is built.

## Test plan
All scenarios use WIDTH=4, MIN_VAL=2, MAX_VAL=12, STEP_W=2 unless stated.
- Reset and enable gating: assert reset for 1 cycle, then enable=0, up=1 for 3 cycles -> out=2, at_min=1, tc=0 throughout.
- Wrap count up (WRAP=1, step=1, up): out steps 2,3,…,12. at_max=1 at 12. The next edge gives out=2 and a single-cycle tc=1.
- Multi-step wrap (WRAP=1): load 11, then step=3 up -> out=3, tc=1. Then step=3 down -> out=11, tc=1. step=0 up -> out=12, tc=0.
- Saturate (WRAP=0): load 11, then step=3 up -> 12, tc=1. Up again -> 12, tc=1. step=1 down -> 11, tc=0.
- Priority and clamping:
  - up=down=1, enable=1 -> out holds, tc=0.
  - load=1, load_val=15, up=1 -> out=12.
  - load_val=0 -> out=2.
  - load with enable=0 still loads.
- UDC_OVF_STICKY_EN defined:
  - A wrap sets ovf=1.
  - ovf_clr on the same edge as a wrap -> ovf stays 1.
  - ovf_clr alone -> ovf=0.
  - reset asserted mid-count -> out=2, ovf=0, tc=0.
